// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN (signed-overflow flag).
package serial_sub_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result valid-ready bundle for the serial subtractor.
// SERIAL_SUB_OVERFLOW_EN adds the overflow signal.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid,
    input  diff, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid,
    output diff, borrow, overflow
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid,
    input  diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid,
    output diff, borrow
  );
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin.
// Purely combinational; used once as the serial datapath.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per clock via one cell.
// SERIAL_SUB_OVERFLOW_EN enables the signed-overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state: load on accept, shift one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        brw_d  = cell_bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = brw_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand MSBs are shifted out, so keep copies for the flag.
  logic amsb_q;
  logic bmsb_q;

  // Capture operand sign bits on the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
    end else if (bus.in_ready && bus.in_valid) begin
      amsb_q <= bus.a[WIDTH-1];
      bmsb_q <= bus.b[WIDTH-1];
    end
  end

  assign bus.overflow = bus.out_valid
                      & (amsb_q ^ bmsb_q)
                      & (diff_q[WIDTH-1] ^ amsb_q);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Overflow checks are compiled in with SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   lat;
  int   first_i;
  int   second_i;
  bit   saw_ready;

  serial_subtractor_if #(.WIDTH(W)) bif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then count cycles to out_valid.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    bif.a        = av;
    bif.b        = bv;
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bif.out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.a         = '0;
    bif.b         = '0;
    bif.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bif.in_ready), 1);
    chk("rst_out_valid", 32'(bif.out_valid), 0);
    chk("rst_diff", 32'(bif.diff), 0);
    chk("rst_borrow", 32'(bif.borrow), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_overflow", 32'(bif.overflow), 0);
`endif
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // 0x5A - 0x3C
    start_op(8'h5A, 8'h3C);
    chk("t1_in_ready_run", 32'(bif.in_ready), 0);
    wait_out(lat);
    chk("t1_latency", 32'(lat), 8);
    chk("t1_diff", 32'(bif.diff), 32'h1E);
    chk("t1_borrow", 32'(bif.borrow), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("t1_overflow", 32'(bif.overflow), 0);
`endif
    tick();
    chk("t1_back_idle", 32'(bif.in_ready), 1);
    chk("t1_valid_drop", 32'(bif.out_valid), 0);

    // 0x00 - 0x01
    start_op(8'h00, 8'h01);
    wait_out(lat);
    chk("t2a_latency", 32'(lat), 8);
    chk("t2a_diff", 32'(bif.diff), 32'hFF);
    chk("t2a_borrow", 32'(bif.borrow), 1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("t2a_overflow", 32'(bif.overflow), 0);
`endif
    tick();

    // 0x80 - 0x01 : signed overflow
    start_op(8'h80, 8'h01);
    wait_out(lat);
    chk("t2b_diff", 32'(bif.diff), 32'h7F);
    chk("t2b_borrow", 32'(bif.borrow), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("t2b_overflow", 32'(bif.overflow), 1);
`endif
    tick();

    // 0x10 - 0x10 with consumer stalled for 5 cycles
    bif.out_ready = 1'b0;
    start_op(8'h10, 8'h10);
    wait_out(lat);
    chk("t3_latency", 32'(lat), 8);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(bif.out_valid), 1);
      chk("t3_hold_diff", 32'(bif.diff), 0);
      chk("t3_hold_borrow", 32'(bif.borrow), 0);
      chk("t3_hold_ready", 32'(bif.in_ready), 0);
      tick();
    end
    chk("t3_still_valid", 32'(bif.out_valid), 1);
    bif.out_ready = 1'b1;
    tick();
    chk("t3_idle_ready", 32'(bif.in_ready), 1);
    chk("t3_idle_valid", 32'(bif.out_valid), 0);

    // Stray in_valid during RUN is ignored
    start_op(8'h05, 8'h03);
    tick();
    tick();
    bif.a        = 8'hFF;
    bif.b        = 8'h00;
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    wait_out(lat);
    chk("t4_latency", 32'(lat), 5);
    chk("t4_diff", 32'(bif.diff), 32'h02);
    chk("t4_borrow", 32'(bif.borrow), 0);
    tick();
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      if (bif.out_valid === 1'b1) lat++;
      tick();
    end
    chk("t4_no_second", 32'(lat), 0);

    // Reset three cycles into RUN
    start_op(8'h77, 8'h11);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(bif.in_ready), 1);
    chk("t5_rst_valid", 32'(bif.out_valid), 0);
    chk("t5_rst_diff", 32'(bif.diff), 0);
    chk("t5_rst_borrow", 32'(bif.borrow), 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bif.out_valid === 1'b1) lat++;
    end
    chk("t5_no_pulse", 32'(lat), 0);
    start_op(8'hC8, 8'h64);
    wait_out(lat);
    chk("t5_latency", 32'(lat), 8);
    chk("t5_diff", 32'(bif.diff), 32'h64);
    chk("t5_borrow", 32'(bif.borrow), 0);
    tick();

    // Back-to-back with in_valid held high
    bif.a        = 8'h33;
    bif.b        = 8'h11;
    bif.in_valid = 1'b1;
    tick();
    bif.a     = 8'h50;
    bif.b     = 8'h60;
    first_i   = -1;
    second_i  = -1;
    saw_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (saw_ready) begin
        bif.in_valid = 1'b0;
        saw_ready    = 1'b0;
      end
      if (bif.out_valid === 1'b1) begin
        if (first_i < 0) begin
          first_i = i;
          chk("t6_first_diff", 32'(bif.diff), 32'h22);
          chk("t6_first_borrow", 32'(bif.borrow), 0);
        end else if (second_i < 0) begin
          second_i = i;
          chk("t6_second_diff", 32'(bif.diff), 32'hF0);
          chk("t6_second_borrow", 32'(bif.borrow), 1);
          break;
        end
      end
      if (first_i >= 0 && bif.in_ready === 1'b1 && bif.in_valid) begin
        saw_ready = 1'b1;
      end
    end
    bif.in_valid = 1'b0;
    chk("t6_first_lat", 32'(first_i), 8);
    chk("t6_gap", 32'(second_i - first_i), 10);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation companion to the team's combinational full-adder datapath, used where area matters more than latency. Operands arrive over a valid/ready input handshake. The difference, final borrow and optional signed-overflow flag are returned over a valid/ready output handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 2
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend, sampled on input handshake
- b  input  WIDTH  subtrahend, sampled on input handshake
- out_valid  output  1  diff/borrow/overflow valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  A − B modulo 2^WIDTH
- borrow  output  1  final borrow-out; 1 iff A < B unsigned
- overflow  output  1  signed overflow (present only with SERIAL_SUB_OVERFLOW_EN)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, load a/b into shift registers, clear the borrow register and the bit counter, then go to RUN.
- RUN:
  - Each cycle, the cell takes ai=a_sh[0], bi=b_sh[0], bin=borrow_reg.
  - d = ai^bi^bin.
  - bout = (~ai&bi) | (~(ai^bi)&bin).
  - d shifts into diff_sh from the MSB side.
  - Operand registers shift right.
  - borrow_reg ← bout.
  - Counter increments.
  - After WIDTH bits, go to DONE.
- DONE:
  - out_valid=1.
  - diff, borrow and overflow are held stable until out_ready=1, then go to IDLE.
- Arithmetic: result is mod 2^WIDTH. borrow equals the bout of bit WIDTH−1.
- in_valid is ignored in RUN and DONE; a and b may change freely there.
- in_valid held in the DONE cycle that has out_ready=1 is not accepted in that cycle (in_ready=0). It is accepted in the following IDLE cycle.
- Counter width is $clog2(WIDTH+1).

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0; counter and shift registers are 0.
- Latency: input handshake at edge t. Bits are processed at edges t+1 … t+WIDTH. out_valid is high from edge t+WIDTH, i.e. WIDTH cycles after acceptance.
- Minimum throughput: one operation per WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE with out_ready=1).
- Output handshake completes on the edge where out_valid & out_ready are both high. in_ready rises on that edge.
- Reset asserted mid-RUN or in DONE: the block goes asynchronously to IDLE and all outputs return to their reset values. The partial result is discarded and no out_valid pulse is produced.
- diff is not guaranteed meaningful outside DONE. The bench checks it only when out_valid=1.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - The overflow port exists.
  - In DONE, overflow = (a_msb≠b_msb) & (diff[WIDTH−1]≠a_msb).
  - a_msb is captured at input handshake.
- Undefined: the overflow port and its MSB capture register are absent. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - the state typedef (IDLE/RUN/DONE enum);
  - the default WIDTH constant.
- Sub-module full_subtractor: combinational, with inputs x, y, bin and outputs d, bout. It is instantiated once as the serial cell.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, out_ready=1 → out_valid after 8 cycles; diff=0x1E, borrow=0, overflow=0.
- a=0x00, b=0x01 → diff=0xFF, borrow=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1 (when enabled).
- a=0x10, b=0x10 with out_ready held low 5 cycles after out_valid → diff=0x00 and borrow=0 held stable; in_ready=0 throughout; IDLE is re-entered on the first out_ready=1 edge.
- in_valid pulsed with a=0xFF, b=0x00 during RUN of a=0x05, b=0x03 → that pulse is ignored; result diff=0x02; no second out_valid.
- rst_n low 3 cycles into RUN → outputs return to reset values at once; the next operation a=0xC8, b=0x64 yields diff=0x64, borrow=0.
- Back-to-back: in_valid held high with a new operand ready as DONE completes → accepted on the next IDLE edge; second result arrives WIDTH+2 cycles after the first.
